// File: rtl/game_phase_sequencer.sv
// Round sequencer for whack-a-mole: countdown, timed play, then a game-over score hold.
// Tracks the live score, the best final score since reset, and the value to show on the display.
module game_phase_sequencer #(
    parameter int unsigned COUNTDOWN_SEC = 5,
    parameter int unsigned GAME_SEC      = 30,
    parameter int unsigned TIME_W        = 8,
    parameter int unsigned SCORE_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_1hz,
    input  logic               hit_pulse,
    input  logic               start,
    output logic [1:0]         phase,
    output logic [31:0]        display_value,
    output logic [TIME_W-1:0]  time_left,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high,
    output logic               led_enable
);

    localparam logic [1:0] PH_COUNTDOWN = 2'b00;
    localparam logic [1:0] PH_PLAY      = 2'b01;
    localparam logic [1:0] PH_OVER      = 2'b10;

    localparam logic [TIME_W-1:0]  TIME_ONE  = TIME_W'(1);
    localparam logic [TIME_W-1:0]  CD_LOAD   = TIME_W'(COUNTDOWN_SEC);
    localparam logic [TIME_W-1:0]  GAME_LOAD = TIME_W'(GAME_SEC);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    logic [1:0]         phase_q, phase_d;
    logic [TIME_W-1:0]  time_left_q, time_left_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_score_q, high_score_d;
    logic               new_high_q, new_high_d;
    logic               led_enable_q, led_enable_d;
    logic [31:0]        display_value_q, display_value_d;
    logic [SCORE_W-1:0] score_hit;

    // Saturating increment; a hit on the final tick still counts toward the final score.
    always_comb begin
        score_hit = score_q;
        if (hit_pulse && (score_q != SCORE_MAX)) begin
            score_hit = score_q + SCORE_W'(1);
        end
    end

    always_comb begin
        phase_d      = phase_q;
        time_left_d  = time_left_q;
        score_d      = score_q;
        high_score_d = high_score_q;
        new_high_d   = 1'b0;

        case (phase_q)
            PH_COUNTDOWN: begin
                if (tick_1hz) begin
                    if (time_left_q > TIME_ONE) begin
                        time_left_d = time_left_q - TIME_ONE;
                    end else begin
                        phase_d     = PH_PLAY;
                        time_left_d = GAME_LOAD;
                        score_d     = '0;
                    end
                end
            end
            PH_PLAY: begin
                score_d = score_hit;
                if (tick_1hz) begin
                    if (time_left_q > TIME_ONE) begin
                        time_left_d = time_left_q - TIME_ONE;
                    end else begin
                        phase_d     = PH_OVER;
                        time_left_d = '0;
                        if (score_hit > high_score_q) begin
                            high_score_d = score_hit;
                            new_high_d   = 1'b1;
                        end
                    end
                end
            end
            PH_OVER: begin
                if (start) begin
                    phase_d     = PH_COUNTDOWN;
                    time_left_d = CD_LOAD;
                end
            end
            default: begin
                // Illegal code recovers exactly like a restart request.
                phase_d     = PH_COUNTDOWN;
                time_left_d = CD_LOAD;
            end
        endcase

        led_enable_d = (phase_d == PH_PLAY);
        if (phase_d == PH_COUNTDOWN) begin
            display_value_d = 32'(time_left_d);
        end else begin
            display_value_d = 32'(score_d);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q         <= PH_COUNTDOWN;
            time_left_q     <= CD_LOAD;
            score_q         <= '0;
            high_score_q    <= '0;
            new_high_q      <= 1'b0;
            led_enable_q    <= 1'b0;
            display_value_q <= 32'(CD_LOAD);
        end else begin
            phase_q         <= phase_d;
            time_left_q     <= time_left_d;
            score_q         <= score_d;
            high_score_q    <= high_score_d;
            new_high_q      <= new_high_d;
            led_enable_q    <= led_enable_d;
            display_value_q <= display_value_d;
        end
    end

    assign phase         = phase_q;
    assign time_left     = time_left_q;
    assign score         = score_q;
    assign high_score    = high_score_q;
    assign new_high      = new_high_q;
    assign led_enable    = led_enable_q;
    assign display_value = display_value_q;

endmodule

// File: tb/tb_game_phase_sequencer.sv
// Bench for game_phase_sequencer: directed vector table, round-level sequences, and
// randomized inputs checked against a round-level reference model.
module tb_game_phase_sequencer;

    localparam int CD    = 5;
    localparam int GAME  = 30;
    localparam int SMAX  = 65535;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_1hz, hit_pulse, start;
    logic [1:0]  phase;
    logic [31:0] display_value;
    logic [7:0]  time_left;
    logic [15:0] score, high_score;
    logic        new_high, led_enable;

    logic        d2_tick, d2_hit, d2_start;
    logic [1:0]  d2_phase;
    logic [31:0] d2_disp;
    logic [7:0]  d2_time;
    logic [3:0]  d2_score, d2_high;
    logic        d2_new_high, d2_led;

    int tests = 0;
    int fails = 0;

    // Reference model state: plain integers describing the round.
    int m_phase, m_time, m_score, m_high, m_new_high;

    always #5 clk = ~clk;

    game_phase_sequencer #(.COUNTDOWN_SEC(CD), .GAME_SEC(GAME), .TIME_W(8), .SCORE_W(16)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .hit_pulse(hit_pulse), .start(start),
        .phase(phase), .display_value(display_value), .time_left(time_left), .score(score),
        .high_score(high_score), .new_high(new_high), .led_enable(led_enable)
    );

    game_phase_sequencer #(.COUNTDOWN_SEC(CD), .GAME_SEC(GAME), .TIME_W(8), .SCORE_W(4)) dut4 (
        .clk(clk), .reset(reset), .tick_1hz(d2_tick), .hit_pulse(d2_hit), .start(d2_start),
        .phase(d2_phase), .display_value(d2_disp), .time_left(d2_time), .score(d2_score),
        .high_score(d2_high), .new_high(d2_new_high), .led_enable(d2_led)
    );

    task automatic model_reset();
        m_phase = 0; m_time = CD; m_score = 0; m_high = 0; m_new_high = 0;
    endtask

    // One clock of the round rules, written in terms of seconds and points.
    task automatic model_clock(input logic t, input logic h, input logic s);
        m_new_high = 0;
        if (m_phase == 0) begin
            if (t) begin
                m_time = m_time - 1;
                if (m_time == 0) begin
                    m_phase = 1; m_time = GAME; m_score = 0;
                end
            end
        end else if (m_phase == 1) begin
            if (h) m_score = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
            if (t) begin
                m_time = m_time - 1;
                if (m_time == 0) begin
                    m_phase = 2;
                    if (m_score > m_high) begin
                        m_high = m_score; m_new_high = 1;
                    end
                end
            end
        end else begin
            if (s) begin
                m_phase = 0; m_time = CD;
            end
        end
    endtask

    task automatic step(input logic t, input logic h, input logic s);
        tick_1hz = t; hit_pulse = h; start = s;
        @(posedge clk);
        model_clock(t, h, s);
        @(negedge clk);
        tick_1hz = 1'b0; hit_pulse = 1'b0; start = 1'b0;
    endtask

    task automatic check_all(input string name);
        int exp_disp;
        exp_disp = (m_phase == 0) ? m_time : m_score;
        tests++;
        if (phase !== 2'(m_phase) || time_left !== 8'(m_time) || score !== 16'(m_score) ||
            high_score !== 16'(m_high) || new_high !== 1'(m_new_high) ||
            display_value !== 32'(exp_disp) || led_enable !== (m_phase == 1)) begin
            fails++;
            $display("FAIL %s: got ph=%0d t=%0d sc=%0d hi=%0d nh=%0d disp=%0d led=%0d; want ph=%0d t=%0d sc=%0d hi=%0d nh=%0d disp=%0d led=%0d",
                     name, phase, time_left, score, high_score, new_high, display_value, led_enable,
                     m_phase, m_time, m_score, m_high, m_new_high, exp_disp, (m_phase == 1));
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Plays a full round from OVER or COUNTDOWN; returns how many new_high pulses were seen.
    task automatic play_round(input int nhits, input bit coincident, output int nh_count);
        nh_count = 0;
        if (m_phase == 2) begin
            step(1'b0, 1'b0, 1'b1);
            check_all("restart");
        end
        for (int i = 0; i < CD; i++) begin
            step(1'b1, 1'b0, 1'b0);
            nh_count += int'(new_high);
        end
        check_all("round_play_entry");
        for (int i = 0; i < (coincident ? nhits - 1 : nhits); i++) begin
            step(1'b0, 1'b1, 1'b0);
            nh_count += int'(new_high);
        end
        for (int i = 0; i < GAME; i++) begin
            step(1'b1, (coincident && i == GAME - 1), 1'b0);
            nh_count += int'(new_high);
        end
        check_all("round_end");
        step(1'b0, 1'b0, 1'b0);
        nh_count += int'(new_high);
        check_all("round_hold");
    endtask

    typedef struct {
        logic t, h, s;
        logic [1:0] ph;
        int tl, sc, disp;
        logic led;
    } vec_t;

    vec_t vecs[9];
    int   nh;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 2'b00,  4, 0, 4, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 2'b00,  3, 0, 3, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 2'b00,  2, 0, 2, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 2'b00,  1, 0, 1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 2'b01, 30, 0, 0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 2'b01, 30, 1, 1, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 2'b01, 29, 2, 2, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 2'b01, 29, 2, 2, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 2'b01, 29, 2, 2, 1'b1};

        reset = 1'b0;
        tick_1hz = 1'b0; hit_pulse = 1'b0; start = 1'b0;
        d2_tick = 1'b0; d2_hit = 1'b0; d2_start = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("reset_phase", 32'(phase), 0);
        check_val("reset_time", 32'(time_left), CD);
        check_val("reset_disp", display_value, CD);
        check_val("reset_led", 32'(led_enable), 0);
        reset = 1'b1;
        @(negedge clk);
        check_all("post_reset");

        foreach (vecs[i]) begin
            step(vecs[i].t, vecs[i].h, vecs[i].s);
            tests++;
            if (phase !== vecs[i].ph || time_left !== 8'(vecs[i].tl) || score !== 16'(vecs[i].sc) ||
                display_value !== 32'(vecs[i].disp) || led_enable !== vecs[i].led) begin
                fails++;
                $display("FAIL vec%0d: got ph=%0d t=%0d sc=%0d disp=%0d led=%0d; want ph=%0d t=%0d sc=%0d disp=%0d led=%0d",
                         i, phase, time_left, score, display_value, led_enable,
                         vecs[i].ph, vecs[i].tl, vecs[i].sc, vecs[i].disp, vecs[i].led);
            end
        end

        // Finish the first round at 7 points.
        repeat (5) step(1'b0, 1'b1, 1'b0);
        repeat (29) step(1'b1, 1'b0, 1'b0);
        check_val("over_phase", 32'(phase), 2);
        check_val("over_score", 32'(score), 7);
        check_val("over_high", 32'(high_score), 7);
        check_val("over_new_high", 32'(new_high), 1);
        check_val("over_disp", display_value, 7);
        check_val("over_led", 32'(led_enable), 0);
        step(1'b0, 1'b0, 1'b0);
        check_val("new_high_one_clk", 32'(new_high), 0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_val("over_hits_ignored", 32'(score), 7);
        check_all("over_hold");
        step(1'b0, 1'b0, 1'b1);
        check_val("restart_phase", 32'(phase), 0);
        check_val("restart_time", 32'(time_left), CD);
        check_val("restart_score_kept", 32'(score), 7);
        step(1'b0, 1'b1, 1'b1);
        check_val("countdown_hit_start_ignored", 32'(score), 7);
        check_all("countdown_hold");

        play_round(4, 1'b1, nh);
        check_val("coincident_final", 32'(score), 4);
        check_val("coincident_nh", nh, 0);
        play_round(5, 1'b0, nh);
        check_val("lower_high", 32'(high_score), 7);
        check_val("lower_nh", nh, 0);
        play_round(7, 1'b0, nh);
        check_val("equal_high", 32'(high_score), 7);
        check_val("equal_nh", nh, 0);
        play_round(9, 1'b0, nh);
        check_val("better_high", 32'(high_score), 9);
        check_val("better_nh", nh, 1);

        // Asynchronous reset mid-PLAY, sampled before any clock edge.
        step(1'b0, 1'b0, 1'b1);
        repeat (CD) step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all("async_reset_release");

        // Illegal phase code forced into the register mid-PLAY.
        repeat (CD + 2) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_all("pre_force");
        force dut.phase_q = 2'b11;
        @(posedge clk);
        #1 release dut.phase_q;
        @(negedge clk);
        check_val("illegal_reload_time", 32'(time_left), CD);
        step(1'b0, 1'b0, 1'b0);
        m_phase = 0; m_time = CD;
        check_all("illegal_recover");

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 20) == 0);
            check_all("random");
        end

        // Narrow score width: saturation and high score at the limit.
        repeat (CD) begin
            d2_tick = 1'b1; @(negedge clk); d2_tick = 1'b0;
        end
        check_val("w4_play", 32'(d2_phase), 1);
        repeat (20) begin
            d2_hit = 1'b1; @(negedge clk); d2_hit = 1'b0;
        end
        check_val("w4_saturate", 32'(d2_score), 15);
        check_val("w4_disp", d2_disp, 15);
        repeat (GAME) begin
            d2_tick = 1'b1; d2_hit = 1'b1; @(negedge clk); d2_tick = 1'b0; d2_hit = 1'b0;
        end
        check_val("w4_over", 32'(d2_phase), 2);
        check_val("w4_high", 32'(d2_high), 15);
        check_val("w4_new_high", 32'(d2_new_high), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
